// File: rtl/dec_stage_1_refill_pkg.sv
// Shared decoder-side definitions for the stage-1 bit-window refill block,
// kept next to the matching encoder-side widths so both ends agree.
package dec_stage_1_refill_pkg;

  localparam int D1_WINDOW_WIDTH_DEF    = 32;
  localparam int D1_RANGE_WIDTH_DEF     = 16;
  localparam int D1_BITSTREAM_WIDTH_DEF = 8;
  localparam int D1_D_SIZE_DEF          = 5;

  // Encoder-side widths the decoder must mirror.
  localparam int E1_RANGE_WIDTH     = 16;
  localparam int E1_BITSTREAM_WIDTH = 8;
  localparam int E1_D_SIZE          = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } d1_state_e;

endpackage

// File: rtl/dec_stage_1_refill_inserter.sv
// Combinational byte inserter: places a new byte directly below the
// already-valid bits of the (possibly just shifted) window.
module d1_byte_inserter #(
  parameter int W  = 32,
  parameter int BW = 8,
  parameter int FW = 6
) (
  input  logic [W-1:0]  shifted_i,
  input  logic [FW-1:0] fill_i,
  input  logic [BW-1:0] byte_i,
  input  logic          insert_i,
  output logic [W-1:0]  window_o
);

  logic [W-1:0] byte_aligned;

  // Bits below the fill point are always zero, so an OR is a clean insert.
  always_comb begin
    byte_aligned = {byte_i, {(W-BW){1'b0}}} >> fill_i;
    window_o     = insert_i ? (shifted_i | byte_aligned) : shifted_i;
  end

endmodule

// File: rtl/dec_stage_1_refill.sv
// Stage-1 refill: keeps a bit window topped up from the byte stream and
// serves variable-length consumes to the decoder core, counting overread.
module dec_stage_1_refill
  import dec_stage_1_refill_pkg::*;
#(
  parameter int D1_WINDOW_WIDTH    = D1_WINDOW_WIDTH_DEF,
  parameter int D1_RANGE_WIDTH     = D1_RANGE_WIDTH_DEF,
  parameter int D1_BITSTREAM_WIDTH = D1_BITSTREAM_WIDTH_DEF,
  parameter int D1_D_SIZE          = D1_D_SIZE_DEF
) (
  input  logic                          d1_clk,
  input  logic                          d1_reset,
  input  logic                          d1_flag_first,
  input  logic [D1_BITSTREAM_WIDTH-1:0] in_byte,
  input  logic                          in_byte_valid,
  input  logic                          in_byte_last,
  output logic                          out_byte_ready,
  input  logic [D1_D_SIZE-1:0]          in_shift,
  input  logic                          in_shift_valid,
  output logic [D1_RANGE_WIDTH-1:0]     out_window,
  output logic                          out_window_valid,
  output logic [D1_D_SIZE:0]            out_fill,
  output logic                          out_done,
  output logic [D1_D_SIZE+10:0]         out_overread
);

  localparam int W   = D1_WINDOW_WIDTH;
  localparam int FW  = D1_D_SIZE + 1;
  localparam int OW  = D1_D_SIZE + 11;
  localparam int OSW = OW + 1;

  localparam logic [D1_D_SIZE-1:0] MaxShift = D1_D_SIZE'(D1_RANGE_WIDTH);
  localparam logic [FW-1:0]        ReadyMax = FW'(D1_WINDOW_WIDTH - D1_BITSTREAM_WIDTH);
  localparam logic [FW-1:0]        RunMin   = FW'(D1_RANGE_WIDTH);
  localparam logic [FW-1:0]        ByteBits = FW'(D1_BITSTREAM_WIDTH);

  d1_state_e state_q, state_d;
  logic [W-1:0]  window_q, window_d, window_shifted, window_ins;
  logic [FW-1:0] fill_q, fill_d, fill_shifted, shift_ext;
  logic [OW-1:0] overread_q, overread_d;
  logic [OSW-1:0] overread_sum;
  logic          eos_q, eos_d;
  logic [D1_D_SIZE-1:0] shift_amt;
  logic          byte_ready, window_valid, done, consume, accept;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=) assignments.
  always_ff @(posedge d1_clk or negedge d1_reset) begin
    if (!d1_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (d1_flag_first) begin
      state_d = ST_FILL;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (accept && in_byte_last) state_d = ST_DRAIN;
          else if (fill_d >= RunMin)  state_d = ST_RUN;
        end
        ST_RUN: begin
          if (accept && in_byte_last)        state_d = ST_DRAIN;
          else if (fill_d < RunMin && !eos_q) state_d = ST_FILL;
        end
        ST_DRAIN: if (fill_d == '0) state_d = ST_DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_ready   = 1'b0;
    window_valid = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      ST_FILL: byte_ready = (fill_q <= ReadyMax);
      ST_RUN: begin
        byte_ready   = (fill_q <= ReadyMax);
        window_valid = 1'b1;
      end
      ST_DRAIN: window_valid = 1'b1;
      ST_DONE: begin
        window_valid = 1'b1;
        done         = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: shift first, then insert; a start pulse overrides both.
  // NOTE: every signal gets a default at the top so no latch is inferred.
  always_comb begin
    shift_amt      = (in_shift > MaxShift) ? MaxShift : in_shift;
    shift_ext      = {1'b0, shift_amt};
    consume        = in_shift_valid & window_valid & ~d1_flag_first;
    accept         = in_byte_valid & byte_ready & ~d1_flag_first;
    window_shifted = window_q;
    fill_shifted   = fill_q;
    overread_sum   = {1'b0, overread_q};
    if (consume) begin
      window_shifted = window_q << shift_amt;
      if (fill_q > shift_ext) begin
        fill_shifted = fill_q - shift_ext;
      end else begin
        fill_shifted = '0;
        overread_sum = {1'b0, overread_q} + OSW'(shift_ext - fill_q);
      end
    end
    fill_d     = accept ? (fill_shifted + ByteBits) : fill_shifted;
    overread_d = overread_sum[OW] ? '1 : overread_sum[OW-1:0];
    eos_d      = eos_q | (accept & in_byte_last);
    window_d   = window_ins;
    if (d1_flag_first) begin
      window_d   = '0;
      fill_d     = '0;
      overread_d = '0;
      eos_d      = 1'b0;
    end
  end

  d1_byte_inserter #(
    .W (W),
    .BW(D1_BITSTREAM_WIDTH),
    .FW(FW)
  ) u_inserter (
    .shifted_i(window_shifted),
    .fill_i   (fill_shifted),
    .byte_i   (in_byte),
    .insert_i (accept),
    .window_o (window_ins)
  );

  always_ff @(posedge d1_clk or negedge d1_reset) begin
    if (!d1_reset) begin
      window_q   <= '0;
      fill_q     <= '0;
      overread_q <= '0;
      eos_q      <= 1'b0;
    end else begin
      window_q   <= window_d;
      fill_q     <= fill_d;
      overread_q <= overread_d;
      eos_q      <= eos_d;
    end
  end

  assign out_byte_ready   = byte_ready;
  assign out_window_valid = window_valid;
  assign out_done         = done;
  assign out_window       = window_q[W-1 -: D1_RANGE_WIDTH];
  assign out_fill         = fill_q;
  assign out_overread     = overread_q;

endmodule

// File: tb/tb_dec_stage_1_refill.sv
// Directed bench for dec_stage_1_refill: expected outputs are queued as each
// step is driven and compared once the DUT has taken the clock edge.
module tb_dec_stage_1_refill;

  logic        d1_clk = 1'b0;
  logic        d1_reset;
  logic        d1_flag_first;
  logic [7:0]  in_byte;
  logic        in_byte_valid;
  logic        in_byte_last;
  logic        out_byte_ready;
  logic [4:0]  in_shift;
  logic        in_shift_valid;
  logic [15:0] out_window;
  logic        out_window_valid;
  logic [5:0]  out_fill;
  logic        out_done;
  logic [15:0] out_overread;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] win;
    logic [5:0]  fill;
    logic        rdy;
    logic        vld;
    logic        done;
    logic [15:0] ovr;
  } exp_t;

  exp_t sb[$];

  always #5 d1_clk = ~d1_clk;

  dec_stage_1_refill dut (
    .d1_clk          (d1_clk),
    .d1_reset        (d1_reset),
    .d1_flag_first   (d1_flag_first),
    .in_byte         (in_byte),
    .in_byte_valid   (in_byte_valid),
    .in_byte_last    (in_byte_last),
    .out_byte_ready  (out_byte_ready),
    .in_shift        (in_shift),
    .in_shift_valid  (in_shift_valid),
    .out_window      (out_window),
    .out_window_valid(out_window_valid),
    .out_fill        (out_fill),
    .out_done        (out_done),
    .out_overread    (out_overread)
  );

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] win,
                            input logic [5:0] fill, input logic rdy,
                            input logic vld, input logic done,
                            input logic [15:0] ovr);
    exp_t e;
    e.tag = tag; e.win = win; e.fill = fill;
    e.rdy = rdy; e.vld = vld; e.done = done; e.ovr = ovr;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "window",   32'(out_window),       32'(e.win));
      chk(e.tag, "fill",     32'(out_fill),         32'(e.fill));
      chk(e.tag, "ready",    32'(out_byte_ready),   32'(e.rdy));
      chk(e.tag, "valid",    32'(out_window_valid), 32'(e.vld));
      chk(e.tag, "done",     32'(out_done),         32'(e.done));
      chk(e.tag, "overread", 32'(out_overread),     32'(e.ovr));
    end
  endtask

  task automatic idle_inputs();
    d1_flag_first  = 1'b0;
    in_byte        = 8'h00;
    in_byte_valid  = 1'b0;
    in_byte_last   = 1'b0;
    in_shift       = 5'd0;
    in_shift_valid = 1'b0;
  endtask

  // Drive one cycle of stimulus, let the edge happen, then score the result.
  task automatic cycle(input logic ff, input logic bv, input logic [7:0] b,
                       input logic last, input logic sv, input logic [4:0] sh);
    d1_flag_first  = ff;
    in_byte_valid  = bv;
    in_byte        = b;
    in_byte_last   = last;
    in_shift_valid = sv;
    in_shift       = sh;
    @(posedge d1_clk);
    #1;
    idle_inputs();
    pop_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    d1_reset = 1'b0;
    #12;
    expect_out("reset", 16'h0000, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    pop_check();
    @(negedge d1_clk);
    d1_reset = 1'b1;

    // Tile start and first two bytes.
    expect_out("start",    16'h0000, 6'd0,  1'b1, 1'b0, 1'b0, 16'h0000); cycle(1, 0, 8'h00, 0, 0, 5'd0);
    expect_out("byte_a5",  16'hA500, 6'd8,  1'b1, 1'b0, 1'b0, 16'h0000); cycle(0, 1, 8'hA5, 0, 0, 5'd0);
    expect_out("byte_3c",  16'hA53C, 6'd16, 1'b1, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'h3C, 0, 0, 5'd0);

    // Backpressure: fill to 32, 5th byte held until a shift of 8.
    expect_out("byte_12",  16'hA53C, 6'd24, 1'b1, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'h12, 0, 0, 5'd0);
    expect_out("byte_34",  16'hA53C, 6'd32, 1'b0, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'h34, 0, 0, 5'd0);
    expect_out("held_56",  16'hA53C, 6'd32, 1'b0, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'h56, 0, 0, 5'd0);
    expect_out("shift8",   16'h3C12, 6'd24, 1'b1, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'h56, 0, 1, 5'd8);
    expect_out("byte_56",  16'h3C12, 6'd32, 1'b0, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'h56, 0, 0, 5'd0);

    // Illegal shift 20 clamps to 16.
    expect_out("clamp20",  16'h3456, 6'd16, 1'b1, 1'b1, 1'b0, 16'h0000); cycle(0, 0, 8'h00, 0, 1, 5'd20);

    // Empty the window: back to FILL, then rebuild 0xA53C_0000.
    expect_out("refill",   16'h0000, 6'd0,  1'b1, 1'b0, 1'b0, 16'h0000); cycle(0, 0, 8'h00, 0, 1, 5'd16);
    expect_out("re_a5",    16'hA500, 6'd8,  1'b1, 1'b0, 1'b0, 16'h0000); cycle(0, 1, 8'hA5, 0, 0, 5'd0);
    expect_out("re_3c",    16'hA53C, 6'd16, 1'b1, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'h3C, 0, 0, 5'd0);

    // Simultaneous shift 4 and byte 0xFF: shift first, then insert.
    expect_out("simul",    16'h53CF, 6'd20, 1'b1, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'hFF, 0, 1, 5'd4);
    expect_out("byte_11",  16'h53CF, 6'd28, 1'b0, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'h11, 0, 0, 5'd0);
    expect_out("shift4",   16'h3CFF, 6'd24, 1'b1, 1'b1, 1'b0, 16'h0000); cycle(0, 0, 8'h00, 0, 1, 5'd4);

    // Restart in RUN with simultaneous byte and shift that must be dropped.
    expect_out("restart",  16'h0000, 6'd0,  1'b1, 1'b0, 1'b0, 16'h0000); cycle(1, 1, 8'h99, 0, 1, 5'd8);
    expect_out("ign_fill", 16'h0000, 6'd0,  1'b1, 1'b0, 1'b0, 16'h0000); cycle(0, 0, 8'h00, 0, 1, 5'd8);

    // Drain: single last byte, then overread past end of stream.
    expect_out("last_80",  16'h8000, 6'd8,  1'b0, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'h80, 1, 0, 5'd0);
    expect_out("drain16",  16'h0000, 6'd0,  1'b0, 1'b1, 1'b1, 16'h0008); cycle(0, 0, 8'h00, 0, 1, 5'd16);
    expect_out("done4",    16'h0000, 6'd0,  1'b0, 1'b1, 1'b1, 16'h000C); cycle(0, 0, 8'h00, 0, 1, 5'd4);

    // Push overread past its maximum; it must stick at all-ones.
    in_shift_valid = 1'b1;
    in_shift       = 5'd16;
    repeat (4096) @(posedge d1_clk);
    #1;
    idle_inputs();
    expect_out("ovr_sat",  16'h0000, 6'd0,  1'b0, 1'b1, 1'b1, 16'hFFFF); cycle(0, 0, 8'h00, 0, 0, 5'd0);

    // Leave DONE with a new tile, enter DRAIN, then abort with reset.
    expect_out("ff_done",  16'h0000, 6'd0,  1'b1, 1'b0, 1'b0, 16'h0000); cycle(1, 0, 8'h00, 0, 0, 5'd0);
    expect_out("last_c3",  16'hC300, 6'd8,  1'b0, 1'b1, 1'b0, 16'h0000); cycle(0, 1, 8'hC3, 1, 0, 5'd0);
    #3;
    d1_reset = 1'b0;
    #1;
    expect_out("async_rst", 16'h0000, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    pop_check();
    @(negedge d1_clk);
    d1_reset = 1'b1;
    expect_out("post_rst", 16'h0000, 6'd0,  1'b0, 1'b0, 1'b0, 16'h0000); cycle(0, 1, 8'h42, 0, 1, 5'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
